fetch_ghr_spec: RTL
===================

Name: fetch_ghr_spec

Overview:
- Parametrised speculative global history register for the fetch-stage branch predictor.
- Keeps two histories:
  - speculative GHR: updated at prediction time.
  - architectural GHR: updated at branch commit.
- Holds a checkpoint queue of in-flight branch histories. On a mispredict, the speculative GHR is restored in one cycle from the offending branch's checkpoint.
- Sits between the fetch predictor (push side) and the backend branch-resolution/commit logic (restore/commit side).

Parameters:
- GHR_WIDTH, 8, history length in bits (>=2).
- CKPT_DEPTH, 8, number of in-flight branch checkpoints (power of two, >=2).
- TAG_WIDTH, log2(CKPT_DEPTH), checkpoint tag width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  fetch predicts a conditional branch this cycle.
- push_taken  in  1  predicted direction (1 = taken).
- push_ready  out  1  queue not full; a push is accepted only when push_valid & push_ready.
- push_tag  out  TAG_WIDTH  tag assigned to the current push (the write slot index).
- commit_valid  in  1  oldest in-flight branch retires.
- commit_taken  in  1  resolved direction of the retiring branch.
- restore_valid  in  1  branch mispredicted, restore the speculative history.
- restore_tag  in  TAG_WIDTH  tag of the mispredicted branch.
- restore_taken  in  1  correct direction of the mispredicted branch.
- flush  in  1  pipeline flush (exception/refetch): discard all speculation.
- spec_ghr  out  GHR_WIDTH  speculative history, registered.
- arch_ghr  out  GHR_WIDTH  committed history, registered.
- count  out  TAG_WIDTH+1  number of occupied checkpoints.
- empty  out  1  count == 0.

Behaviour:
- Shift rule: shift(h,t) = {h[GHR_WIDTH-2:0], t}; the newest bit is the LSB.
- Storage:
  - read/write pointers rptr/wptr, each TAG_WIDTH+1 bits (MSB is the wrap bit).
  - full when pointer LSBs are equal and MSBs differ.
  - ckpt[CKPT_DEPTH] of GHR_WIDTH bits each.
- Reset: spec_ghr=0, arch_ghr=0, rptr=wptr=0, count=0, empty=1, push_ready=1. ckpt contents are don't-care.
- All outputs are registered; an update takes effect at the next rising edge (1-cycle latency). push_tag is combinational, = wptr[TAG_WIDTH-1:0].
- Push (accepted, no restore, no flush):
  - ckpt[wptr] <= spec_ghr (pre-shift value).
  - spec_ghr <= shift(spec_ghr, push_taken).
  - wptr++.
- Push while full: ignored, no state change; push_ready=0 signals the stall.
- Commit (count>0):
  - arch_ghr <= shift(arch_ghr, commit_taken).
  - rptr++.
- Commit while empty: ignored (assertion in bench).
- Restore:
  - spec_ghr <= shift(ckpt[restore_tag], restore_taken).
  - wptr <= {wrap bit of that slot, restore_tag} + 1. The mispredicted branch stays in flight; all younger checkpoints are discarded.
  - restore_tag must address an occupied slot; any other tag is illegal (assertion).
- Priority, highest first: reset > flush > restore > push.
  - Commit is independent and is applied alongside any of flush/restore/push in the same cycle.
- Flush:
  - spec_ghr <= post-commit arch_ghr value (includes a same-cycle commit).
  - wptr <= rptr_next, so count becomes 0.
  - A push in the same cycle is dropped.
- Restore + push in the same cycle: push dropped, push_tag ignored by the consumer.
- Restore + commit in the same cycle, with restore_tag == oldest: legal. Result: count=0, spec_ghr restored, arch_ghr shifted.
- Push + commit in the same cycle when full: commit proceeds; push is still rejected because push_ready is evaluated on the current count.
- Wrap-around: pointers wrap modulo 2*CKPT_DEPTH; tags wrap modulo CKPT_DEPTH. Occupancy is unaffected by the wrap.
- count = wptr - rptr (TAG_WIDTH+1-bit arithmetic).

Test Plan:
- Reset then 3 pushes taken=1,0,1 (W=8, D=4) -> spec_ghr=0x05, push_tag=0,1,2, ckpt={0x00,0x01,0x02}, count=3, arch_ghr=0x00.
- Fill: 4 pushes all taken -> spec_ghr=0x0F, count=4, push_ready=0; 5th push -> spec_ghr unchanged at 0x0F, count stays 4.
- Restore: from 0x05 state (count=3), restore_tag=1, restore_taken=1 -> spec_ghr=0x03, count=2, next push_tag=2.
- Commit sequence 1,0,1 with no pushes after the first test -> arch_ghr=0x05, count=0, empty=1; a 4th commit is ignored.
- Flush with simultaneous commit taken=1, arch_ghr=0x02 and 2 in flight -> arch_ghr=0x05, spec_ghr=0x05, count=0; a same-cycle push is dropped.
- Wrap: 6 push/commit pairs (D=4) then restore to the tag of the oldest live entry -> correct checkpoint selected across pointer wrap; reset asserted mid-stream -> all state returns to reset values next cycle.

Source files
------------

// File: rtl/fetch_ghr_spec.sv
// Speculative/architectural global history register pair with a checkpoint
// queue of in-flight branch histories for one-cycle mispredict recovery.
module fetch_ghr_spec #(
  parameter int unsigned  GHR_WIDTH  = 8,
  parameter int unsigned  CKPT_DEPTH = 8,
  localparam int unsigned TAG_WIDTH  = $clog2(CKPT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_valid,
  input  logic                 push_taken,
  output logic                 push_ready,
  output logic [TAG_WIDTH-1:0] push_tag,
  input  logic                 commit_valid,
  input  logic                 commit_taken,
  input  logic                 restore_valid,
  input  logic [TAG_WIDTH-1:0] restore_tag,
  input  logic                 restore_taken,
  input  logic                 flush,
  output logic [GHR_WIDTH-1:0] spec_ghr,
  output logic [GHR_WIDTH-1:0] arch_ghr,
  output logic [TAG_WIDTH:0]   count,
  output logic                 empty
);

  typedef logic [GHR_WIDTH-1:0] ghr_t;
  typedef logic [TAG_WIDTH:0]   ptr_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t FULL_CNT = ptr_t'(CKPT_DEPTH);

  function automatic ghr_t shift_in(input ghr_t h, input logic t);
    return {h[GHR_WIDTH-2:0], t};
  endfunction

  ghr_t spec_q, spec_d;
  ghr_t arch_q, arch_d;
  ptr_t rptr_q, rptr_d;
  ptr_t wptr_q, wptr_d;
  ptr_t count_q, count_d;
  logic empty_q, empty_d;
  logic ready_q, ready_d;

  ghr_t ckpt_q [CKPT_DEPTH];
  logic ckpt_we;

  logic push_ok;
  logic commit_ok;
  tag_t restore_off;
  ptr_t restore_ptr;

  // The restored slot's full pointer (with wrap bit) is recovered from its
  // distance to the oldest entry, so wrap-around needs no extra state.
  always_comb begin
    push_ok     = push_valid & ready_q;
    commit_ok   = commit_valid & ~empty_q;
    restore_off = restore_tag - rptr_q[TAG_WIDTH-1:0];
    restore_ptr = rptr_q + {1'b0, restore_off};

    spec_d  = spec_q;
    arch_d  = arch_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    ckpt_we = 1'b0;

    if (commit_ok) begin
      arch_d = shift_in(arch_q, commit_taken);
      rptr_d = rptr_q + PTR_ONE;
    end

    if (flush) begin
      spec_d = arch_d;
      wptr_d = rptr_d;
    end else if (restore_valid) begin
      spec_d = shift_in(ckpt_q[restore_tag], restore_taken);
      wptr_d = restore_ptr + PTR_ONE;
    end else if (push_ok) begin
      ckpt_we = 1'b1;
      spec_d  = shift_in(spec_q, push_taken);
      wptr_d  = wptr_q + PTR_ONE;
    end

    count_d = wptr_d - rptr_d;
    empty_d = (count_d == '0);
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_q  <= '0;
      arch_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      spec_q  <= spec_d;
      arch_q  <= arch_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ckpt_we && !reset) begin
      ckpt_q[wptr_q[TAG_WIDTH-1:0]] <= spec_q;
    end
  end

  assign spec_ghr   = spec_q;
  assign arch_ghr   = arch_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign push_ready = ready_q;
  assign push_tag   = wptr_q[TAG_WIDTH-1:0];

endmodule
